serial_cmd_master: RTL and testbench

//  Host-side initiator for the ASCII-hex command protocol served by the serial controller.
//  It accepts one request: an opcode char plus an optional 16-bit argument.
//  It emits the argument as 4 lowercase hex chars (MSB nibble first), then the opcode char.
//  It then parses the controller's reply (4 echoed digits, ' ', 'x', 4 hex digits) into a 16-bit result.

---
 rtl/serial_cmd_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_serial_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_master.sv
// -----------------------------------------------------------------------------
// serial_cmd_master
//
// Host-side initiator for the ASCII-hex command protocol served by a remote
// serial controller. It takes one request at a time. A request is an opcode
// character plus an optional 16-bit argument. The module transmits the
// argument as four lowercase hex characters (MSB nibble first), followed by
// the opcode. It then parses the controller's reply into a 16-bit result.
// The expected reply is: four echoed digits, ' ', 'x', then four hex digits.
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high while idle; a request is accepted on a clk edge
//                   where req_valid && req_ready
//   req_op     in   opcode character (never 0-9 / a-f)
//   req_wdata  in   argument, sent as hex; ignored when req_nodata is set
//   req_nodata in   1: send the opcode only, without digits
//   rsp_valid  out  one-cycle strobe: the response is complete
//   rsp_data   out  parsed reply value; held until the next rsp_valid
//   rsp_err    out  0 ok, 1 timeout, 2 echo/frame error, 3 opcode unrecognised
//   xmit       out  byte write strobe towards the serial transmitter FIFO
//   txchar     out  byte to transmit, valid with xmit
//   rxstrobe   in   received-byte strobe from the serial receiver
//   rxbyte     in   received byte, valid with rxstrobe
// -----------------------------------------------------------------------------
module serial_cmd_master #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd400000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_wdata,
    input  logic        req_nodata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        xmit,
    output logic [7:0]  txchar,
    input  logic        rxstrobe,
    input  logic [7:0]  rxbyte
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_RX   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_OPCODE  = 2'd3;

    // Nibble to lowercase ASCII hex: '0'..'9' then 'a'..'f' (0x61 - 10 = 0x57).
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Byte number idx of the outgoing frame: four digits then the opcode.
    function automatic logic [7:0] tx_byte(input logic [7:0] op, input logic [15:0] wd,
                                           input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hex_char(wd[15:12]);
            3'd1:    b = hex_char(wd[11:8]);
            3'd2:    b = hex_char(wd[7:4]);
            3'd3:    b = hex_char(wd[3:0]);
            default: b = op;
        endcase
        return b;
    endfunction

    logic [1:0]  state_reg;
    logic [7:0]  op_reg;
    logic [15:0] wdata_reg;
    logic [2:0]  tx_idx_reg;   // index of the byte currently presented on txchar
    logic [3:0]  rxpos_reg;    // position within the reply frame of the next rx byte
    logic [15:0] acc_reg;
    logic [23:0] tmo_reg;

    assign req_ready = (state_reg == S_IDLE);

    // ---------------------------------------------------------------------
    // Received-byte classification
    // ---------------------------------------------------------------------
    logic        rx_is_hex;
    logic [3:0]  rx_nib;
    logic [1:0]  rx_err;
    logic [15:0] acc_next;

    always_comb begin
        rx_is_hex = 1'b0;
        rx_nib    = 4'd0;
        if (rxbyte >= 8'h30 && rxbyte <= 8'h39) begin
            rx_is_hex = 1'b1;
            rx_nib    = rxbyte[3:0];
        end else if (rxbyte >= 8'h61 && rxbyte <= 8'h66) begin
            rx_is_hex = 1'b1;
            rx_nib    = rxbyte[3:0] + 4'd9;   // 'a' has low nibble 1 -> 10
        end
    end

    assign acc_next = {acc_reg[11:0], rx_nib};

    always_comb begin
        rx_err = ERR_OK;
        if (rxpos_reg < 4'd4) begin
            // The echo must match what we sent, digit for digit.
            if (rxbyte != tx_byte(op_reg, wdata_reg, {1'b0, rxpos_reg[1:0]})) begin
                rx_err = ERR_FRAME;
            end
        end else if (rxpos_reg == 4'd4) begin
            // The controller echoes the opcode back in place of ' ' when it
            // does not recognise it.
            if (rxbyte == 8'h20) begin
                rx_err = ERR_OK;
            end else if (rxbyte == op_reg) begin
                rx_err = ERR_OPCODE;
            end else begin
                rx_err = ERR_FRAME;
            end
        end else if (rxpos_reg == 4'd5) begin
            if (rxbyte != 8'h78) begin
                rx_err = ERR_FRAME;
            end
        end else if (!rx_is_hex) begin
            rx_err = ERR_FRAME;
        end
    end

    // ---------------------------------------------------------------------
    // Completion detection (error, final digit, or timeout)
    // ---------------------------------------------------------------------
    logic        fin;
    logic [1:0]  fin_err;
    logic [15:0] fin_data;
    logic        tmo_hit;

    assign tmo_hit = (tmo_reg >= TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        fin      = 1'b0;
        fin_err  = ERR_OK;
        fin_data = 16'h0000;
        if (state_reg == S_TX || state_reg == S_RX) begin
            if (rxstrobe) begin
                if (rx_err != ERR_OK) begin
                    fin     = 1'b1;
                    fin_err = rx_err;
                end else if (rxpos_reg == 4'd9) begin
                    fin      = 1'b1;
                    fin_data = acc_next;
                end
            end else if (tmo_hit) begin
                // A byte arriving on the deadline cycle wins over the timeout.
                fin     = 1'b1;
                fin_err = ERR_TIMEOUT;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Main sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            op_reg     <= 8'h00;
            wdata_reg  <= 16'h0000;
            tx_idx_reg <= 3'd0;
            rxpos_reg  <= 4'd0;
            acc_reg    <= 16'h0000;
            tmo_reg    <= 24'd0;
            xmit       <= 1'b0;
            txchar     <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_data   <= 16'h0000;
            rsp_err    <= ERR_OK;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // Bytes arriving while idle are stray replies and are dropped.
                    if (req_valid) begin
                        op_reg     <= req_op;
                        wdata_reg  <= req_wdata;
                        tmo_reg    <= 24'd0;
                        acc_reg    <= 16'h0000;
                        rxpos_reg  <= req_nodata ? 4'd4 : 4'd0;
                        tx_idx_reg <= req_nodata ? 3'd4 : 3'd0;
                        xmit       <= 1'b1;
                        txchar     <= req_nodata ? req_op : hex_char(req_wdata[15:12]);
                        state_reg  <= S_TX;
                    end
                end

                S_TX, S_RX: begin
                    if (state_reg == S_TX) begin
                        if (tx_idx_reg == 3'd4) begin
                            xmit      <= 1'b0;
                            txchar    <= 8'h00;
                            state_reg <= S_RX;
                        end else begin
                            tx_idx_reg <= tx_idx_reg + 3'd1;
                            txchar     <= tx_byte(op_reg, wdata_reg, tx_idx_reg + 3'd1);
                        end
                    end

                    // Reply bytes are accepted in TX too: a fast controller may
                    // start echoing before the last byte has left.
                    if (rxstrobe) begin
                        tmo_reg   <= 24'd0;
                        rxpos_reg <= rxpos_reg + 4'd1;
                        if (rxpos_reg >= 4'd6) begin
                            acc_reg <= acc_next;
                        end
                    end else if (tmo_reg != 24'hffffff) begin
                        tmo_reg <= tmo_reg + 24'd1;
                    end

                    // Overrides the TX step above: an early error aborts the send.
                    if (fin) begin
                        state_reg <= S_DONE;
                        xmit      <= 1'b0;
                        txchar    <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_data  <= fin_data;
                        rsp_err   <= fin_err;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_serial_cmd_master
//
// Self-checking bench for serial_cmd_master. Directed vectors come from a
// table. Randomised requests and replies are checked against a reference
// model of the reply-frame rules. Hand-written sequences cover timeout,
// reply bytes during TX, and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_serial_cmd_master;

    localparam logic [23:0] TMO   = 24'd200;
    localparam int          TMO_I = 200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_nodata = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        xmit;
    logic [7:0]  txchar;
    logic        rxstrobe = 1'b0;
    logic [7:0]  rxbyte = 8'h00;

    serial_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_wdata(req_wdata), .req_nodata(req_nodata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .xmit(xmit), .txchar(txchar), .rxstrobe(rxstrobe), .rxbyte(rxbyte)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  op;
        logic [15:0] wdata;
        logic        nodata;
        int          exp_err;
        logic [15:0] exp_data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Per-transaction observation state, shared by tick()/sample().
    int          npulse, cyc, bytes_sent, got_err, got_used, got_cyc;
    logic [15:0] got_data;
    logic        got_ready;

    string digits = "0123456789abcdef";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        if (rsp_valid === 1'b1) begin
            npulse++;
            if (npulse == 1) begin
                got_err   = int'(rsp_err);
                got_data  = rsp_data;
                got_used  = bytes_sent;
                got_cyc   = cyc;
                got_ready = req_ready;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        sample();
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s.getc(i));
        return q;
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        for (int i = 0; i < 16; i++) if (digits.getc(i) == c) return i;
        return -1;
    endfunction

    // Reference: walk the reply against the expected frame layout.
    function automatic void ref_model(input logic [7:0] op, input logic [15:0] wd, input logic nd,
                                      input bq_t rep, output int err, output logic [15:0] data,
                                      output int used);
        logic [7:0] echo [4];
        int val;
        int pos;
        int hv;
        bit ok;
        for (int i = 0; i < 4; i++) echo[i] = digits.getc(int'((wd >> (12 - 4 * i)) & 16'hf));
        err = 1; data = 16'h0000; used = -1; val = 0;
        for (int k = 0; k < rep.size(); k++) begin
            pos = (nd ? 4 : 0) + k;
            hv  = hex_val(rep[k]);
            ok  = 1'b0;
            if (pos < 4) begin
                ok = (rep[k] == echo[pos]);
            end else if (pos == 4) begin
                if (rep[k] == " ") ok = 1'b1;
                else if (rep[k] == op) begin err = 3; used = k + 1; return; end
            end else if (pos == 5) begin
                ok = (rep[k] == "x");
            end else begin
                ok  = (hv >= 0);
                val = val * 16 + hv;
            end
            if (!ok) begin err = 2; used = k + 1; return; end
            if (pos == 9) begin err = 0; data = 16'(val); used = k + 1; return; end
        end
    endfunction

    task automatic start_req(input logic [7:0] op, input logic [15:0] wd, input logic nd);
        req_valid = 1'b1; req_op = op; req_wdata = wd; req_nodata = nd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 8'($urandom); req_wdata = 16'($urandom); req_nodata = 1'($urandom);
    endtask

    task automatic run_txn(input string name, input logic [7:0] op, input logic [15:0] wd,
                           input logic nd, input bq_t rep, input int exp_err,
                           input logic [15:0] exp_data, input int exp_used);
        bq_t txq;
        bit  txbad;
        int  w;
        txbad = 1'b0;
        if (!nd) for (int i = 3; i >= 0; i--) txq.push_back(digits.getc(int'((wd >> (4 * i)) & 16'hf)));
        txq.push_back(op);
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check({name, ".ready"}, req_ready, 1);
        npulse = 0; cyc = 0; bytes_sent = 0; got_err = -1; got_used = -1; got_cyc = -1;
        got_data = 16'hxxxx; got_ready = 1'bx;
        start_req(op, wd, nd);
        for (int i = 0; i < txq.size(); i++) begin
            tick();
            if (!(xmit === 1'b1 && txchar === txq[i])) txbad = 1'b1;
        end
        check({name, ".txbytes"}, 32'(txbad), 0);
        tick();
        check({name, ".txend"}, xmit, 0);
        for (int k = 0; k < rep.size(); k++) begin
            repeat ($urandom_range(0, 2)) tick();
            rxstrobe = 1'b1; rxbyte = rep[k];
            bytes_sent++;
            tick();
            rxstrobe = 1'b0;
        end
        for (int i = 0; i < TMO_I + 20 && npulse == 0; i++) tick();
        repeat (4) tick();
        check({name, ".rsp_count"}, npulse, 1);
        check({name, ".rsp_err"}, got_err, exp_err);
        check({name, ".rsp_data"}, got_data, exp_data);
        check({name, ".ready_in_done"}, got_ready, 0);
        if (rep.size() > 0) check({name, ".rsp_after_byte"}, got_used, exp_used);
        else check({name, ".timeout_latency_ok"}, 32'(got_cyc >= TMO_I && got_cyc <= TMO_I + 2), 1);
        check({name, ".rsp_data_held"}, rsp_data, exp_data);
        $display("txn %s op=%c nodata=%0d wdata=%h -> rsp_err=%0d rsp_data=%h after_byte=%0d cyc=%0d",
                 name, op, nd, wd, got_err, got_data, got_used, got_cyc);
    endtask

    task automatic reset_mid(input string name);
        @(posedge clk);
        #3;
        resetn = 1'b0; rxstrobe = 1'b0;
        #1;
        check({name, ".xmit"}, xmit, 0);
        check({name, ".txchar"}, txchar, 0);
        check({name, ".rsp_valid"}, rsp_valid, 0);
        check({name, ".rsp_data"}, rsp_data, 0);
        check({name, ".rsp_err"}, rsp_err, 0);
        check({name, ".req_ready"}, req_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        $display("txn %s async reset applied mid-transfer", name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    vec_t  vecs [9];
    string vec_reply [9];
    string vec_name [9];

    initial begin
        int          e, u;
        logic [15:0] d;
        bq_t         rep;
        string       ops  = "rwsQzRm";
        string       junk = "0123456789abcdefAFxX Q?r";
        logic [7:0]  op;
        logic [15:0] wd, val;
        logic        nd;

        vecs[0] = '{8'h72, 16'h12af, 1'b0, 0, 16'hbeef}; vec_reply[0] = "12af xbeef";  vec_name[0] = "basic_r";
        vecs[1] = '{8'h73, 16'h5555, 1'b1, 0, 16'h0000}; vec_reply[1] = " x0000";      vec_name[1] = "nodata_s";
        vecs[2] = '{8'h51, 16'h0000, 1'b0, 3, 16'h0000}; vec_reply[2] = "0000Q x12";   vec_name[2] = "unrec_Q";
        vecs[3] = '{8'h72, 16'h12af, 1'b0, 2, 16'h0000}; vec_reply[3] = "13af xbeef";  vec_name[3] = "bad_echo";
        vecs[4] = '{8'h77, 16'h00ff, 1'b0, 2, 16'h0000}; vec_reply[4] = "00ff x00A0";  vec_name[4] = "upper_hex";
        vecs[5] = '{8'h72, 16'hffff, 1'b0, 0, 16'hffff}; vec_reply[5] = "ffff xffff";  vec_name[5] = "all_f";
        vecs[6] = '{8'h72, 16'h9a50, 1'b0, 2, 16'h0000}; vec_reply[6] = "9a50 y1234";  vec_name[6] = "bad_x";
        vecs[7] = '{8'h67, 16'h0000, 1'b1, 2, 16'h0000}; vec_reply[7] = "?x0000";      vec_name[7] = "bad_space";
        vecs[8] = '{8'h52, 16'h0000, 1'b1, 3, 16'h0000}; vec_reply[8] = "R x0000";     vec_name[8] = "nodata_unrec";

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.req_ready", req_ready, 1);
        check("reset.xmit", xmit, 0);
        check("reset.txchar", txchar, 0);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_data", rsp_data, 0);
        check("reset.rsp_err", rsp_err, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            rep = str2q(vec_reply[i]);
            ref_model(vecs[i].op, vecs[i].wdata, vecs[i].nodata, rep, e, d, u);
            run_txn(vec_name[i], vecs[i].op, vecs[i].wdata, vecs[i].nodata, rep,
                    vecs[i].exp_err, vecs[i].exp_data, u);
        end

        // Timeout: no reply at all
        rep = {};
        run_txn("timeout", 8'h72, 16'h0001, 1'b0, rep, 1, 16'h0000, 0);

        // Echo byte arriving while still transmitting aborts the send
        npulse = 0; cyc = 0; bytes_sent = 0;
        start_req(8'h72, 16'h3000, 1'b0);
        rxstrobe = 1'b1; rxbyte = "9";
        @(negedge clk);
        check("rx_in_tx.first_byte", {xmit, txchar}, {1'b1, 8'h33});
        @(posedge clk);
        #1;
        rxstrobe = 1'b0;
        @(negedge clk);
        check("rx_in_tx.rsp_valid", rsp_valid, 1);
        check("rx_in_tx.rsp_err", rsp_err, 2);
        check("rx_in_tx.xmit_off", xmit, 0);
        $display("txn rx_in_tx op=r wdata=3000 -> rsp_err=%0d", rsp_err);
        repeat (3) @(negedge clk);

        // Randomised requests against the reference model
        for (int t = 0; t < 60; t++) begin
            op  = ops.getc($urandom_range(0, ops.len() - 1));
            wd  = 16'($urandom);
            nd  = ($urandom_range(0, 3) == 0);
            val = 16'($urandom);
            rep = {};
            if (!nd) for (int i = 3; i >= 0; i--) rep.push_back(digits.getc(int'((wd >> (4 * i)) & 16'hf)));
            rep.push_back(" ");
            rep.push_back("x");
            for (int i = 3; i >= 0; i--) rep.push_back(digits.getc(int'((val >> (4 * i)) & 16'hf)));
            if ($urandom_range(0, 2) == 0)
                rep[$urandom_range(0, rep.size() - 1)] = junk.getc($urandom_range(0, junk.len() - 1));
            repeat ($urandom_range(0, 2)) rep.push_back(junk.getc($urandom_range(0, junk.len() - 1)));
            ref_model(op, wd, nd, rep, e, d, u);
            run_txn($sformatf("rand%0d", t), op, wd, nd, rep, e, d, u);
        end

        // Reset mid-TX, then mid-RX; each followed by a normal transaction
        run_txn("pre_reset", 8'h72, 16'h1111, 1'b0, str2q("1111 x4321"), 0, 16'h4321, 10);
        start_req(8'h77, 16'habcd, 1'b0);
        reset_mid("reset_tx");
        run_txn("post_reset_tx", 8'h72, 16'h0f0f, 1'b0, str2q("0f0f x8001"), 0, 16'h8001, 10);

        start_req(8'h72, 16'h5a5a, 1'b0);
        repeat (6) @(negedge clk);
        rxstrobe = 1'b1; rxbyte = "5";
        @(negedge clk);
        rxbyte = "a";
        @(negedge clk);
        rxstrobe = 1'b0;
        reset_mid("reset_rx");
        npulse = 0; cyc = 0; bytes_sent = 0;
        rep = str2q("5a x1234");
        for (int k = 0; k < rep.size(); k++) begin
            rxstrobe = 1'b1; rxbyte = rep[k];
            tick();
            rxstrobe = 1'b0;
        end
        repeat (10) tick();
        check("reset_rx.no_rsp", npulse, 0);
        run_txn("post_reset_rx", 8'h73, 16'h0000, 1'b1, str2q(" x7e57"), 0, 16'h7e57, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
